// File: rtl/inst_mem_pkg.sv
// Shared types and defaults for the instruction fetch memory.
// Fault codes are reported on resp_fault alongside the returned word.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  localparam int INST_W_DEF = 32;
  localparam logic [INST_W_DEF-1:0] NOP_DEF = '0;

endpackage

// File: rtl/inst_mem_array.sv
// Purpose: DEPTH x INST_W instruction storage, optional load port under INST_MEM_LOAD_EN.
// Latency: read data registered one edge after rd_en; write lands on the same edge.
// Backpressure: none; rd_data holds while rd_en is low.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [INST_W-1:0] rd_data
`ifdef INST_MEM_LOAD_EN
  ,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [INST_W-1:0] wr_data
`endif
);

  logic [INST_W-1:0] mem [DEPTH];

  // Both ports sample mem before the edge, so a same-index read returns the old word.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_idx];
`ifdef INST_MEM_LOAD_EN
    if (wr_en) mem[wr_idx] <= wr_data;
`endif
  end

endmodule

// File: rtl/inst_fetch_mem.sv
// Purpose: instruction memory with valid/ready fetch port and fault codes; INST_MEM_LOAD_EN adds a load port.
// Latency: response valid exactly one edge after an accepted request.
// Backpressure: one-entry output stage; req_ready drops while a response is stalled.
module inst_fetch_mem
  import inst_mem_pkg::*;
#(
  parameter int                INST_W    = INST_W_DEF,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 128,
  parameter int                BYTE_ADDR = 1,
  parameter logic [INST_W-1:0] NOP_INST  = INST_W'(NOP_DEF),
  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [INST_W-1:0] resp_inst,
  output logic [1:0]        resp_fault,
  output logic [31:0]       fetch_count
`ifdef INST_MEM_LOAD_EN
  ,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_addr,
  input  logic [INST_W-1:0] load_data
`endif
);

  localparam int OFF_W = $clog2(INST_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  logic [ADDR_W-1:0] idx_full;
  logic              misalign;
  logic              out_of_range;
  fault_e            fault_d;
  fault_e            fault_q;
  logic              accept;
  logic [INST_W-1:0] rd_data;

  // Range check uses the full-width index so large addresses never alias into the array.
  always_comb begin
    idx_full     = (BYTE_ADDR != 0) ? (req_addr >> OFF_W) : req_addr;
    misalign     = (BYTE_ADDR != 0) && ((req_addr & OFF_MASK) != '0);
    out_of_range = 64'(idx_full) >= 64'(DEPTH);
    fault_d      = misalign ? FAULT_MISALIGN : (out_of_range ? FAULT_RANGE : FAULT_NONE);
  end

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;

  inst_mem_array #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_arr (
    .clock   (clock),
    .rd_en   (accept && (fault_d == FAULT_NONE)),
    .rd_idx  (idx_full[IDX_W-1:0]),
    .rd_data (rd_data)
`ifdef INST_MEM_LOAD_EN
    ,
    .wr_en   (load_en),
    .wr_idx  (load_addr),
    .wr_data (load_data)
`endif
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid  <= 1'b0;
      fault_q     <= FAULT_NONE;
      fetch_count <= '0;
    end else if (accept) begin
      resp_valid  <= 1'b1;
      fault_q     <= fault_d;
      fetch_count <= fetch_count + 32'd1;
    end else if (resp_ready) begin
      resp_valid  <= 1'b0;
    end
  end

  // Array data is not reset; gate it so an idle or faulting slot never exposes stale words.
  always_comb begin
    resp_fault = fault_q;
    if (!resp_valid)                resp_inst = '0;
    else if (fault_q != FAULT_NONE) resp_inst = NOP_INST;
    else                            resp_inst = rd_data;
  end

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench: byte-addressed DEPTH=128 instance plus word-addressed DEPTH=16 instance.
module tb_inst_fetch_mem;

  logic        clock = 1'b0;
  logic        reset_n;
  int          passed = 0;
  int          total  = 0;
  int          exp_cnt;

  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [31:0] a_req_addr, a_resp_inst, a_fetch_count;
  logic [1:0]  a_resp_fault;
  logic        a_load_en;
  logic [6:0]  a_load_addr;
  logic [31:0] a_load_data;

  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [31:0] b_req_addr, b_resp_inst, b_fetch_count;
  logic [1:0]  b_resp_fault;
  logic        b_load_en;
  logic [3:0]  b_load_addr;
  logic [31:0] b_load_data;

  logic [31:0] vals [4];

  always #5 clock = ~clock;

  inst_fetch_mem #(.DEPTH(128), .BYTE_ADDR(1)) u_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (a_req_valid),
    .req_ready   (a_req_ready),
    .req_addr    (a_req_addr),
    .resp_valid  (a_resp_valid),
    .resp_ready  (a_resp_ready),
    .resp_inst   (a_resp_inst),
    .resp_fault  (a_resp_fault),
    .fetch_count (a_fetch_count)
`ifdef INST_MEM_LOAD_EN
    ,
    .load_en     (a_load_en),
    .load_addr   (a_load_addr),
    .load_data   (a_load_data)
`endif
  );

  inst_fetch_mem #(.DEPTH(16), .BYTE_ADDR(0)) u_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (b_req_valid),
    .req_ready   (b_req_ready),
    .req_addr    (b_req_addr),
    .resp_valid  (b_resp_valid),
    .resp_ready  (b_resp_ready),
    .resp_inst   (b_resp_inst),
    .resp_fault  (b_resp_fault),
    .fetch_count (b_fetch_count)
`ifdef INST_MEM_LOAD_EN
    ,
    .load_en     (b_load_en),
    .load_addr   (b_load_addr),
    .load_data   (b_load_data)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    vals[0] = 32'h0000_0005;
    vals[1] = 32'h0000_0450;
    vals[2] = 32'h0000_0458;
    vals[3] = 32'h0000_0550;
    reset_n = 1'b0;
    a_req_valid = 1'b0; a_req_addr = '0; a_resp_ready = 1'b0;
    a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b1;
    b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
    exp_cnt = 0;

    tick();
    check("rst_resp_valid", a_resp_valid, 0);
    check("rst_resp_inst", a_resp_inst, 0);
    check("rst_resp_fault", a_resp_fault, 0);
    check("rst_fetch_count", a_fetch_count, 0);
    check("rst_req_ready", a_req_ready, 1);

    // Preload while reset is still asserted.
`ifdef INST_MEM_LOAD_EN
    for (int i = 0; i < 4; i++) begin
      a_load_en = 1'b1; a_load_addr = 7'(i); a_load_data = vals[i];
      tick();
    end
    a_load_en = 1'b0;
    b_load_en = 1'b1; b_load_addr = 4'd3; b_load_data = 32'hABCD_0003;
    tick();
    b_load_en = 1'b0;
`else
    for (int i = 0; i < 4; i++) u_a.u_arr.mem[i] = vals[i];
    u_b.u_arr.mem[3] = 32'hABCD_0003;
    tick();
`endif
    #3 reset_n = 1'b1;

    // Back-to-back fetch of four words.
    a_req_valid = 1'b1; a_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_req_addr = 32'(i * 4);
      tick();
      exp_cnt++;
      check("b2b_valid", a_resp_valid, 1);
      check("b2b_inst", a_resp_inst, vals[i]);
      check("b2b_fault", a_resp_fault, 0);
    end
    a_req_valid = 1'b0;
    check("b2b_count", a_fetch_count, 32'd4);
    tick();
    check("drain_valid", a_resp_valid, 0);

    // Stall with a pending next request.
    a_req_valid = 1'b1; a_req_addr = 32'd4; a_resp_ready = 1'b0;
    tick();
    exp_cnt++;
    a_req_addr = 32'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_req_ready", a_req_ready, 0);
      check("stall_inst", a_resp_inst, 32'h450);
      check("stall_valid", a_resp_valid, 1);
      tick();
    end
    check("stall_count", a_fetch_count, 32'(exp_cnt));
    a_resp_ready = 1'b1;
    #1;
    check("unstall_req_ready", a_req_ready, 1);
    tick();
    exp_cnt++;
    check("unstall_inst", a_resp_inst, 32'h458);
    check("unstall_count", a_fetch_count, 32'(exp_cnt));

    // Faulting fetches: misaligned, range, both, huge address.
    a_req_addr = 32'd6;
    tick(); exp_cnt++;
    check("mis_fault", a_resp_fault, 2'b01);
    check("mis_inst", a_resp_inst, 0);
    a_req_addr = 32'd512;
    tick(); exp_cnt++;
    check("range_fault", a_resp_fault, 2'b10);
    check("range_inst", a_resp_inst, 0);
    a_req_addr = 32'd513;
    tick(); exp_cnt++;
    check("both_fault", a_resp_fault, 2'b01);
    a_req_addr = 32'h8000_0000;
    tick(); exp_cnt++;
    check("huge_fault", a_resp_fault, 2'b10);
    check("huge_valid", a_resp_valid, 1);
    a_req_valid = 1'b0;
    check("fault_count", a_fetch_count, 32'(exp_cnt));
    tick();

    // Load and fetch of the same index on the same edge.
    a_req_valid = 1'b1; a_req_addr = 32'd8;
`ifdef INST_MEM_LOAD_EN
    a_load_en = 1'b1; a_load_addr = 7'd2; a_load_data = 32'h0000_07C0;
    tick(); exp_cnt++;
    a_load_en = 1'b0;
    check("rbw_old", a_resp_inst, 32'h458);
`else
    u_a.u_arr.mem[2] = 32'h0000_07C0;
`endif
    tick(); exp_cnt++;
    check("rbw_new", a_resp_inst, 32'h7C0);
    a_req_valid = 1'b0;
    check("rbw_count", a_fetch_count, 32'(exp_cnt));
    tick();

    // Asynchronous reset in the middle of a stall.
    a_req_valid = 1'b1; a_req_addr = 32'd4; a_resp_ready = 1'b0;
    tick();
    a_req_valid = 1'b0;
    check("pre_rst_valid", a_resp_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", a_resp_valid, 0);
    check("async_rst_count", a_fetch_count, 0);
    check("async_rst_inst", a_resp_inst, 0);
    tick();
    #3 reset_n = 1'b1;
    a_req_valid = 1'b1; a_req_addr = 32'd4; a_resp_ready = 1'b1;
    tick();
    a_req_valid = 1'b0;
    check("post_rst_inst", a_resp_inst, 32'h450);
    check("post_rst_count", a_fetch_count, 32'd1);

    // Word-addressed instance.
    b_req_valid = 1'b1; b_req_addr = 32'd3;
    tick();
    check("word_inst", b_resp_inst, 32'hABCD_0003);
    check("word_fault", b_resp_fault, 0);
    b_req_addr = 32'd16;
    tick();
    check("word_range_fault", b_resp_fault, 2'b10);
    check("word_range_inst", b_resp_inst, 0);
    b_req_valid = 1'b0;
    check("word_count", b_fetch_count, 32'd2);
    tick();
    check("word_drain", b_resp_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
